// File: rtl/nios_fprint_dct_pkg.sv
// Shared types and sizing for the OCI trace DCT packer.
// Holds the fill FSM states and the atom insert helper.
package nios_fprint_dct_pkg;

    localparam int ATOM_W         = 3;
    localparam int ATOMS_PER_WORD = 10;
    localparam int BUF_W          = ATOM_W * ATOMS_PER_WORD;
    localparam int CNT_W          = 4;
    localparam int DROP_CNT_W     = 16;

    typedef enum logic [1:0] {
        FILL  = 2'd0,
        FULL  = 2'd1,
        FLUSH = 2'd2,
        ENDED = 2'd3
    } dct_state_t;

    function automatic logic [BUF_W-1:0] pack_atom(
        input logic [BUF_W-1:0]  b,
        input logic [ATOM_W-1:0] a,
        input logic [CNT_W-1:0]  slot
    );
        logic [BUF_W-1:0] r;
        r = b;
        for (int i = 0; i < ATOMS_PER_WORD; i++) begin
            if (slot == CNT_W'(i)) begin
                r[i*ATOM_W +: ATOM_W] = a;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/nios_fprint_dct_out_reg.sv
// One-entry output register for packed DCT words.
// Loads only when free; holds data/count frozen while the sink stalls.
module nios_fprint_dct_out_reg
    import nios_fprint_dct_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic [BUF_W-1:0] data_i,
    input  logic [CNT_W-1:0] count_i,
    input  logic             ready_i,
    output logic             free_o,
    output logic             valid_o,
    output logic [BUF_W-1:0] data_o,
    output logic [CNT_W-1:0] count_o
);

    logic             valid_q;
    logic [BUF_W-1:0] data_q;
    logic [CNT_W-1:0] count_q;

    assign free_o  = !valid_q || ready_i;
    assign valid_o = valid_q;
    assign data_o  = data_q;
    assign count_o = count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            count_q <= '0;
        end else if (free_o) begin
            valid_q <= load_i;
            if (load_i) begin
                data_q  <= data_i;
                count_q <= count_i;
            end
        end
    end

endmodule

// File: rtl/nios_fprint_dct_pack_ctrl.sv
// OCI trace DCT packer: fills 10x3-bit atoms, hands words off, runs flush.
// Optional macro DCT_DROP_CNT_EN adds a saturating dropped-atom counter.
module nios_fprint_dct_pack_ctrl
    import nios_fprint_dct_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        atom_valid,
    input  logic [2:0]  atom_data,
    input  logic        flush_req,
    output logic [29:0] dct_buffer,
    output logic [3:0]  dct_count,
    output logic        word_valid,
    output logic [29:0] word_data,
    output logic [3:0]  word_count,
    input  logic        word_ready,
    output logic        flush_done,
    output logic        busy,
    output logic [15:0] drop_count
);

    dct_state_t       state_q, state_d;
    logic [BUF_W-1:0] buf_q, buf_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             flush_q;

    logic             out_free;
    logic             load;
    logic [BUF_W-1:0] load_data;
    logic [CNT_W-1:0] load_cnt;
    logic             flush_rise;
    logic [BUF_W-1:0] buf_ins;
    logic [CNT_W-1:0] cnt_ins;

    assign flush_rise = flush_req && !flush_q;
    assign buf_ins    = pack_atom(buf_q, atom_data, cnt_q);
    assign cnt_ins    = cnt_q + CNT_W'(1);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= FILL;
            buf_q   <= '0;
            cnt_q   <= '0;
            flush_q <= 1'b0;
        end else begin
            state_q <= state_d;
            buf_q   <= buf_d;
            cnt_q   <= cnt_d;
            flush_q <= flush_req;
        end
    end

    always_comb begin
        state_d   = state_q;
        buf_d     = buf_q;
        cnt_d     = cnt_q;
        load      = 1'b0;
        load_data = buf_q;
        load_cnt  = cnt_q;
        unique case (state_q)
            FILL: begin
                if (atom_valid) begin
                    if (cnt_ins == CNT_W'(ATOMS_PER_WORD)) begin
                        if (out_free) begin
                            load      = 1'b1;
                            load_data = buf_ins;
                            load_cnt  = cnt_ins;
                            buf_d     = '0;
                            cnt_d     = '0;
                        end else begin
                            buf_d   = buf_ins;
                            cnt_d   = cnt_ins;
                            state_d = FULL;
                        end
                    end else begin
                        buf_d = buf_ins;
                        cnt_d = cnt_ins;
                    end
                end
                if (flush_rise) begin
                    state_d = FLUSH;
                end
            end
            FULL: begin
                // Draining frees slot 0 for an atom arriving the same cycle.
                if (out_free) begin
                    load    = 1'b1;
                    state_d = FILL;
                    if (atom_valid) begin
                        buf_d = pack_atom('0, atom_data, '0);
                        cnt_d = CNT_W'(1);
                    end else begin
                        buf_d = '0;
                        cnt_d = '0;
                    end
                end
                if (flush_rise) begin
                    state_d = FLUSH;
                end
            end
            FLUSH: begin
                if (cnt_q != '0) begin
                    if (out_free) begin
                        load  = 1'b1;
                        buf_d = '0;
                        cnt_d = '0;
                    end
                end else if (!word_valid) begin
                    state_d = ENDED;
                end
            end
            ENDED: begin
                if (!flush_req) begin
                    state_d = FILL;
                end
            end
            default: state_d = FILL;
        endcase
    end

    nios_fprint_dct_out_reg u_out_reg (
        .clk     (clk),
        .rst_n   (reset_n),
        .load_i  (load),
        .data_i  (load_data),
        .count_i (load_cnt),
        .ready_i (word_ready),
        .free_o  (out_free),
        .valid_o (word_valid),
        .data_o  (word_data),
        .count_o (word_count)
    );

    assign dct_buffer = buf_q;
    assign dct_count  = cnt_q;
    assign flush_done = (state_q == ENDED);
    assign busy       = (cnt_q != '0) || word_valid;

`ifdef DCT_DROP_CNT_EN
    logic                  drop_inc;
    logic [DROP_CNT_W-1:0] drop_q, drop_d;

    always_comb begin
        drop_inc = atom_valid &&
                   ((state_q == FLUSH) ||
                    ((state_q == FULL) && !out_free));
        drop_d = drop_q;
        if (drop_inc && (drop_q != '1)) begin
            drop_d = drop_q + DROP_CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            drop_q <= '0;
        end else begin
            drop_q <= drop_d;
        end
    end

    assign drop_count = drop_q;
`else
    assign drop_count = '0;
`endif

endmodule

// File: tb/tb_nios_fprint_dct_pack_ctrl.sv
// Directed self-checking bench for nios_fprint_dct_pack_ctrl.
// Build with DCT_DROP_CNT_EN to exercise the drop counter.
module tb_nios_fprint_dct_pack_ctrl;

    logic        clk;
    logic        reset_n;
    logic        atom_valid;
    logic [2:0]  atom_data;
    logic        flush_req;
    logic [29:0] dct_buffer;
    logic [3:0]  dct_count;
    logic        word_valid;
    logic [29:0] word_data;
    logic [3:0]  word_count;
    logic        word_ready;
    logic        flush_done;
    logic        busy;
    logic [15:0] drop_count;

    int errors = 0;
    int checks = 0;

`ifdef DCT_DROP_CNT_EN
    localparam logic [15:0] EXP_DROP = 16'd5;
`else
    localparam logic [15:0] EXP_DROP = 16'd0;
`endif

    nios_fprint_dct_pack_ctrl dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .atom_valid (atom_valid),
        .atom_data  (atom_data),
        .flush_req  (flush_req),
        .dct_buffer (dct_buffer),
        .dct_count  (dct_count),
        .word_valid (word_valid),
        .word_data  (word_data),
        .word_count (word_count),
        .word_ready (word_ready),
        .flush_done (flush_done),
        .busy       (busy),
        .drop_count (drop_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic atom(input logic [2:0] a);
        atom_valid = 1'b1;
        atom_data  = a;
        tick();
        atom_valid = 1'b0;
    endtask

    initial begin
        reset_n    = 1'b0;
        atom_valid = 1'b0;
        atom_data  = '0;
        flush_req  = 1'b0;
        word_ready = 1'b1;
        tick();
        tick();
        chk("rst_wvalid", word_valid, 0);
        chk("rst_dcount", dct_count, 0);
        chk("rst_dbuf", dct_buffer, 0);
        chk("rst_fdone", flush_done, 0);
        chk("rst_busy", busy, 0);
        chk("rst_drop", drop_count, 0);
        reset_n = 1'b1;
        tick();

        // 1: full word with sink ready
        for (int i = 0; i < 9; i++) atom(3'(i % 8));
        chk("t1_cnt9", dct_count, 9);
        chk("t1_wv_pre", word_valid, 0);
        atom(3'd1);
        chk("t1_wvalid", word_valid, 1);
        chk("t1_wdata", word_data, 30'o1076543210);
        chk("t1_wcount", word_count, 10);
        chk("t1_dcount", dct_count, 0);
        tick();
        chk("t1_consumed", word_valid, 0);

        // 2: stalled sink, fill to FULL, drop 5
        word_ready = 1'b0;
        for (int i = 0; i < 10; i++) atom(3'd5);
        chk("t2_w1valid", word_valid, 1);
        for (int i = 0; i < 10; i++) atom(3'd2);
        for (int i = 0; i < 5; i++) atom(3'd7);
        chk("t2_wdata", word_data, 30'o5555555555);
        chk("t2_wcount", word_count, 10);
        chk("t2_dcount", dct_count, 10);
        chk("t2_dbuf", dct_buffer, 30'o2222222222);
        chk("t2_drop", drop_count, EXP_DROP);
        chk("t2_busy", busy, 1);

        // 3: release in FULL with atom arriving
        word_ready = 1'b1;
        atom(3'd3);
        chk("t3_wvalid", word_valid, 1);
        chk("t3_wdata", word_data, 30'o2222222222);
        chk("t3_wcount", word_count, 10);
        chk("t3_dcount", dct_count, 1);
        chk("t3_dbuf", dct_buffer, 3);
        tick();
        chk("t3_consumed", word_valid, 0);
        chk("t3_drop", drop_count, EXP_DROP);

        // 4: partial word flushed
        atom(3'd4);
        atom(3'd5);
        atom(3'd6);
        chk("t4_dbuf", dct_buffer, 30'o6543);
        flush_req = 1'b1;
        tick();
        chk("t4_cnt_fl", dct_count, 4);
        chk("t4_fd0", flush_done, 0);
        tick();
        chk("t4_wvalid", word_valid, 1);
        chk("t4_wdata", word_data, 30'o6543);
        chk("t4_wcount", word_count, 4);
        chk("t4_dcount", dct_count, 0);
        tick();
        chk("t4_consumed", word_valid, 0);
        chk("t4_fd_wait", flush_done, 0);
        tick();
        chk("t4_fdone", flush_done, 1);
        chk("t4_busy", busy, 0);
        atom(3'd7);
        chk("t4_ended_drop", drop_count, EXP_DROP);
        chk("t4_ended_cnt", dct_count, 0);
        flush_req = 1'b0;
        tick();
        chk("t4_fd_clr", flush_done, 0);

        // 5: flush with empty buffer and idle output
        flush_req = 1'b1;
        tick();
        chk("t5_fd0", flush_done, 0);
        tick();
        chk("t5_fdone", flush_done, 1);
        chk("t5_noword", word_valid, 0);
        flush_req = 1'b0;
        tick();
        chk("t5_fd_clr", flush_done, 0);

        // 6: reset mid-flush with word pending
        word_ready = 1'b0;
        atom(3'd1);
        atom(3'd2);
        flush_req = 1'b1;
        tick();
        tick();
        chk("t6_wvalid", word_valid, 1);
        chk("t6_wdata", word_data, 30'o21);
        chk("t6_wcount", word_count, 2);
        reset_n = 1'b0;
        #1;
        chk("t6_rst_wv", word_valid, 0);
        chk("t6_rst_wd", word_data, 0);
        chk("t6_rst_wc", word_count, 0);
        chk("t6_rst_cnt", dct_count, 0);
        chk("t6_rst_busy", busy, 0);
        chk("t6_rst_drop", drop_count, 0);
        flush_req = 1'b0;
        tick();
        reset_n = 1'b1;
        tick();
        atom(3'd6);
        chk("t6_dbuf", dct_buffer, 6);
        chk("t6_dcount", dct_count, 1);
        chk("t6_fdone", flush_done, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
